fetch_instruction_buffer: RTL and testbench

FETCH_INSTRUCTION_BUFFER -- requirements
Module: fetch_instruction_buffer

---
 rtl/cva5_types.sv | 24 ++
 rtl/fetch_buffer_ram.sv | 26 ++
 rtl/fetch_instruction_buffer.sv | 98 +++++++++
 tb/tb_fetch_instruction_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cva5_types.sv
// Shared types for the fetch path: the instruction buffer entry and its packing helper.
package cva5_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        fetch_fault;
  } fetch_buffer_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_buffer_entry_t);

  function automatic fetch_buffer_entry_t make_fetch_entry(
    input logic [31:0] pc,
    input logic [31:0] instruction,
    input logic        fetch_fault
  );
    fetch_buffer_entry_t e;
    e.pc          = pc;
    e.instruction = instruction;
    e.fetch_fault = fetch_fault;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer: synchronous write, asynchronous read, no reset on contents.
module fetch_buffer_ram
  import cva5_types::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                write_en,
  input  logic [AW-1:0]       write_addr,
  input  fetch_buffer_entry_t write_data,
  input  logic [AW-1:0]       read_addr,
  output fetch_buffer_entry_t read_data
);

  fetch_buffer_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fetch_instruction_buffer.sv
// Fetch-to-decode instruction FIFO with flush. Define FETCH_BUF_BYPASS_EN to let an entry pushed
// into an empty buffer be presented on pop_* in the same cycle.
module fetch_instruction_buffer
  import cva5_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instruction,
  input  logic                     push_fetch_fault,
  output logic                     pop_valid,
  input  logic                     pop,
  output logic [31:0]              pop_pc,
  output logic [31:0]              pop_instruction,
  output logic                     pop_fetch_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  fetch_buffer_entry_t push_entry;
  fetch_buffer_entry_t ram_entry;
  fetch_buffer_entry_t pop_entry;
  logic                bypass;
  logic                push_acc;
  logic                pop_acc;
  logic                wr_en;
  logic                rd_en;

  // Bypass is gated by rst_n so pop_valid stays low for the whole reset assertion.
`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = rst_n && (count == '0) && push && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push_ready = (count < FULL_COUNT);
  assign pop_valid  = (count != '0) || bypass;

  assign push_acc = push && push_ready && !flush;
  assign pop_acc  = pop && pop_valid && !flush;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en = push_acc && !(bypass && pop);
  assign rd_en = pop_acc && !bypass;

  assign push_entry = make_fetch_entry(push_pc, push_instruction, push_fetch_fault);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  fetch_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk        (clk),
    .write_en   (wr_en),
    .write_addr (wr_ptr),
    .write_data (push_entry),
    .read_addr  (rd_ptr),
    .read_data  (ram_entry)
  );

  assign pop_entry       = bypass ? push_entry : ram_entry;
  assign pop_pc          = pop_entry.pc;
  assign pop_instruction = pop_entry.instruction;
  assign pop_fetch_fault = pop_entry.fetch_fault;

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
// Scoreboard bench for fetch_instruction_buffer; follows FETCH_BUF_BYPASS_EN like the design.
module tb_fetch_instruction_buffer;
  import cva5_types::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instruction;
  logic        push_fetch_fault;
  logic        pop_valid;
  logic        pop;
  logic [31:0] pop_pc;
  logic [31:0] pop_instruction;
  logic        pop_fetch_fault;
  logic [2:0]  count;

  fetch_instruction_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .push             (push),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_instruction (push_instruction),
    .push_fetch_fault (push_fetch_fault),
    .pop_valid        (pop_valid),
    .pop              (pop),
    .pop_pc           (pop_pc),
    .pop_instruction  (pop_instruction),
    .pop_fetch_fault  (pop_fetch_fault),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mcount = 0;
  fetch_buffer_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completed pop is compared against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && pop_valid === 1'b1 && pop === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected actual_pc=%0h required=no entry at %0t", pop_pc, $time);
        end else begin
          chk("pop_pc", pop_pc, exp_q[0].pc);
          chk("pop_instruction", pop_instruction, exp_q[0].instruction);
          chk("pop_fetch_fault", {31'd0, pop_fetch_fault}, {31'd0, exp_q[0].fetch_fault});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic p, input logic [31:0] pc, input logic [31:0] ins,
                      input logic f, input logic po, input logic fl);
    bit byp;
    bit acc_push;
    bit acc_pop;
    push             = p;
    push_pc          = pc;
    push_instruction = ins;
    push_fetch_fault = f;
    pop              = po;
    flush            = fl;
    byp      = BYP && (mcount == 0) && p && !fl;
    acc_push = p && (mcount < DEPTH) && !fl;
    acc_pop  = po && ((mcount != 0) || byp) && !fl;
    if (fl) exp_q.delete();
    else if (acc_push) exp_q.push_back(make_fetch_entry(pc, ins, f));
    @(negedge clk);
    chk("push_ready", {31'd0, push_ready}, {31'd0, (mcount < DEPTH)});
    chk("pop_valid", {31'd0, pop_valid}, {31'd0, ((mcount != 0) || byp)});
    chk("count", {29'd0, count}, 32'(mcount));
    @(posedge clk);
    #1;
    if (fl) mcount = 0;
    else mcount = mcount + int'(acc_push) - int'(acc_pop);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    push_pc = '0;
    push_instruction = '0;
    push_fetch_fault = 1'b0;
    #12;
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("reset_push_ready", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_push_ready", {31'd0, push_ready}, 32'd0);
    for (int i = 0; i < 4; i++) do_pop();
    chk("drain_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("drain_count", {29'd0, count}, 32'd0);

    // Illegal handshakes and fault propagation.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i), (i == 2), 1'b0, 1'b0);
    step(1'b1, 32'h3F0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("full_push_ignored", {29'd0, count}, 32'd4);
    step(1'b1, 32'h3F4, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("full_pop_no_refill", {29'd0, count}, 32'd3);
    for (int i = 0; i < 3; i++) do_pop();
    do_pop();
    chk("empty_pop_ignored", {29'd0, count}, 32'd0);

    // Concurrent push+pop at count=2 across pointer wrap.
    step(1'b1, 32'h400, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h408 + 32'(4 * i), 32'hC000_0002 + 32'(i), i[0], 1'b1, 1'b0);
    chk("concurrent_count", {29'd0, count}, 32'd2);
    do_pop();
    do_pop();

    // Flush with push and pop high discards everything.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5FC, 32'hD000_00FF, 1'b0, 1'b1, 1'b1);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_pop_valid", {31'd0, pop_valid}, 32'd0);
    do_pop();
    step(1'b1, 32'h600, 32'hE000_0000, 1'b1, 1'b0, 1'b0);
    do_pop();

    // Empty push with pop high: bypass or one-cycle latency depending on build.
    step(1'b1, 32'h200, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    chk("bypass_count", {29'd0, count}, BYP ? 32'd0 : 32'd1);
    do_pop();
    chk("bypass_after_count", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h700 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    push = 1'b0;
    pop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", {29'd0, count}, 32'd0);
    chk("async_reset_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("async_reset_push_ready", {31'd0, push_ready}, 32'd1);
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h800, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    chk("post_reset_count", {29'd0, count}, 32'd1);
    do_pop();
    idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
